requant_gain_ctrl: RTL and testbench

REQUANT_GAIN_CTRL -- requirements
Module: requant_gain_ctrl

---
 rtl/requant_gain_ctrl.sv | 145 ++++++++++++++
 tb/tb_requant_gain_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/requant_gain_ctrl.sv
// Per-channel gain sequencer for the requantiser: double-buffered gain banks
// with boundary-aligned swap, sync realignment and per-spectrum overflow count.
module requant_gain_ctrl #(
  parameter int unsigned GAIN_WIDTH   = 11,
  parameter int unsigned CHANNELS     = 2048,
  parameter int unsigned DEFAULT_GAIN = 1,
  localparam int unsigned AW          = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  sync_in,
  output logic [GAIN_WIDTH-1:0] gain_out,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [GAIN_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_drop,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  active_bank,
  output logic                  sync_err,
  input  logic                  ovfl_in,
  input  logic                  ovfl_sync_in,
  output logic [AW:0]           ovfl_count
);

  localparam int unsigned      CW        = AW + 1;
  localparam logic [AW-1:0]    LAST_CHAN = AW'(CHANNELS - 1);
  localparam logic [CW-1:0]    ACC_MAX   = '1;
  localparam logic [GAIN_WIDTH-1:0] DEF_GAIN = GAIN_WIDTH'(DEFAULT_GAIN);

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t           state;
  logic [GAIN_WIDTH-1:0] bank [2][CHANNELS];
  logic [AW-1:0]         chan;
  logic [AW-1:0]         next_chan;
  logic                  bypass;
  logic                  sync_seen;
  logic                  boundary;
  logic                  rd_bank;
  logic                  shadow_bank;
  logic [CW-1:0]         ovfl_acc;

  assign wr_ready    = (state == IDLE);
  assign shadow_bank = ~active_bank;

  // Next channel index; a sync forces the following cycle to channel 1.
  always_comb begin
    next_chan = chan + AW'(1);
    if (sync_in)
      next_chan = AW'(1);
    else if (chan == LAST_CHAN)
      next_chan = '0;
  end

  // The swap fires on the last channel so the channel-0 prefetch already
  // reads the new bank; a realigning sync on that cycle defers it.
  always_comb begin
    boundary = ce && !sync_in && (chan == LAST_CHAN) && (state == PENDING);
    rd_bank  = boundary ? shadow_bank : active_bank;
  end

  // Host writes into the shadow bank, independent of ce.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ready)
      bank[shadow_bank][wr_addr] <= wr_data;
  end

  // Channel counter, gain prefetch and sync alignment check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chan        <= '0;
      gain_out    <= DEF_GAIN;
      bypass      <= 1'b1;
      sync_seen   <= 1'b0;
      sync_err    <= 1'b0;
      active_bank <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (ce) begin
        chan <= next_chan;
        if (bypass && !boundary)
          gain_out <= DEF_GAIN;
        else
          gain_out <= bank[rd_bank][next_chan];
        if (sync_in) begin
          sync_seen <= 1'b1;
          if (sync_seen && (chan != '0))
            sync_err <= 1'b1;
        end
        if (boundary) begin
          active_bank <= shadow_bank;
          bypass      <= 1'b0;
        end
      end
    end
  end

  // Swap request state machine and refused-write flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      swap_done <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (swap_req)
            state <= PENDING;
        end
        PENDING: begin
          if (boundary) begin
            swap_done <= 1'b1;
            state     <= swap_req ? PENDING : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A write refused on the swap cycle itself is still a lost write.
      if (boundary)
        wr_drop <= 1'b0;
      if (wr_en && !wr_ready)
        wr_drop <= 1'b1;
    end
  end

  // Saturating overflow accumulator, snapshotted on each output sync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovfl_acc   <= '0;
      ovfl_count <= '0;
    end else if (ce) begin
      if (ovfl_sync_in) begin
        ovfl_count <= ovfl_acc;
        ovfl_acc   <= CW'(ovfl_in);
      end else if (ovfl_in && (ovfl_acc != ACC_MAX)) begin
        ovfl_acc <= ovfl_acc + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_requant_gain_ctrl.sv
// Directed self-checking bench for requant_gain_ctrl (12-bit gains so that
// the k+2 ramp up to 2049 is representable).
module tb_requant_gain_ctrl;

  localparam int GW   = 12;
  localparam int CH   = 2048;
  localparam int AW   = 11;
  localparam int LAST = CH - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic          sync_in;
  logic [GW-1:0] gain_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [GW-1:0] wr_data;
  logic          wr_ready;
  logic          wr_drop;
  logic          swap_req;
  logic          swap_done;
  logic          active_bank;
  logic          sync_err;
  logic          ovfl_in;
  logic          ovfl_sync_in;
  logic [AW:0]   ovfl_count;

  int n_tests = 0;
  int n_fail  = 0;

  requant_gain_ctrl #(
    .GAIN_WIDTH  (GW),
    .CHANNELS    (CH),
    .DEFAULT_GAIN(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .sync_in     (sync_in),
    .gain_out    (gain_out),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .wr_drop     (wr_drop),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .active_bank (active_bank),
    .sync_err    (sync_err),
    .ovfl_in     (ovfl_in),
    .ovfl_sync_in(ovfl_sync_in),
    .ovfl_count  (ovfl_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; host pulses are single-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    swap_req = 1'b0;
  endtask

  // One ce cycle: gain for the presented channel, then no sync error.
  task automatic run_cycle(input bit sync, input int exp_gain, input string tag);
    check_eq(tag, 32'(gain_out), exp_gain);
    ce      = 1'b1;
    sync_in = sync;
    tick();
    sync_in = 1'b0;
    check_eq({tag, "_sync_err"}, 32'(sync_err), 0);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; sync_in = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; swap_req = 1'b0; ovfl_in = 1'b0; ovfl_sync_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    check_eq("rst_gain", 32'(gain_out), 1);
    check_eq("rst_wr_ready", 32'(wr_ready), 1);
    check_eq("rst_wr_drop", 32'(wr_drop), 0);
    check_eq("rst_active_bank", 32'(active_bank), 0);
    check_eq("rst_swap_done", 32'(swap_done), 0);
    check_eq("rst_sync_err", 32'(sync_err), 0);
    check_eq("rst_ovfl_count", 32'(ovfl_count), 0);

    // Three spectra in bypass.
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < CH; i++)
        run_cycle(i == 0, 1, "bypass");

    // Fill shadow bank 1 with k+2, then swap mid-spectrum.
    ce = 1'b0;
    for (int k = 0; k < CH; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = GW'(k + 2);
      tick();
    end
    check_eq("fill_wr_drop", 32'(wr_drop), 0);
    check_eq("fill_active_bank", 32'(active_bank), 0);
    for (int i = 0; i < CH; i++) begin
      if (i == 1000) swap_req = 1'b1;
      run_cycle(i == 0, 1, "swap_wait_gain");
      if (i == 1000) check_eq("pending_wr_ready", 32'(wr_ready), 0);
      if (i < LAST) begin
        if (i % 512 == 0) check_eq("early_swap_done", 32'(swap_done), 0);
      end else begin
        check_eq("swap1_done", 32'(swap_done), 1);
        check_eq("swap1_active_bank", 32'(active_bank), 1);
      end
    end
    for (int i = 0; i < CH; i++) begin
      run_cycle(i == 0, i + 2, "bank1_gain");
      if (i < 2) check_eq("swap1_done_once", 32'(swap_done), 0);
    end
    check_eq("post_swap_wr_ready", 32'(wr_ready), 1);

    // Fill bank 0 with 4000-k; a write while pending must be refused.
    ce = 1'b0;
    for (int k = 0; k < CH; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = GW'(4000 - k);
      tick();
    end
    for (int i = 0; i < CH; i++) begin
      if (i == 10) swap_req = 1'b1;
      if (i == 20) begin
        check_eq("drop_wr_ready", 32'(wr_ready), 0);
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = GW'(7);
      end
      run_cycle(i == 0, i + 2, "pend_gain");
      if (i == 20 || i == LAST - 1) check_eq("wr_drop_set", 32'(wr_drop), 1);
      if (i == LAST) begin
        check_eq("swap2_done", 32'(swap_done), 1);
        check_eq("swap2_wr_drop_clr", 32'(wr_drop), 0);
        check_eq("swap2_active_bank", 32'(active_bank), 0);
      end
    end

    // Bank 0 active (channel 5 keeps 3995); ce freeze while a swap is pending.
    for (int i = 0; i < CH; i++) begin
      if (i == 400) swap_req = 1'b1;
      if (i == 500) begin
        for (int f = 0; f < 10; f++) begin
          ce = 1'b0;
          tick();
          check_eq("freeze_gain", 32'(gain_out), 3500);
          check_eq("freeze_wr_ready", 32'(wr_ready), 0);
          check_eq("freeze_swap_done", 32'(swap_done), 0);
          check_eq("freeze_sync_err", 32'(sync_err), 0);
        end
      end
      run_cycle(i == 0, 4000 - i, "bank0_gain");
      if (i == LAST) begin
        check_eq("swap3_done", 32'(swap_done), 1);
        check_eq("swap3_active_bank", 32'(active_bank), 1);
      end
    end

    // Misaligned sync 100 cycles into a spectrum.
    for (int i = 0; i < 100; i++)
      run_cycle(i == 0, i + 2, "presync_gain");
    check_eq("missync_gain", 32'(gain_out), 102);
    ce = 1'b1; sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check_eq("missync_err", 32'(sync_err), 1);
    for (int j = 1; j < CH; j++)
      run_cycle(1'b0, j + 2, "realign_gain");
    for (int i = 0; i < CH; i++)
      run_cycle(i == 0, i + 2, "aligned_gain");

    // Overflow accumulator.
    ce = 1'b1; ovfl_sync_in = 1'b1; ovfl_in = 1'b0;
    tick();
    ovfl_sync_in = 1'b0;
    repeat (3) tick();
    ovfl_in = 1'b1;
    repeat (5) tick();
    ovfl_in = 1'b0;
    repeat (2) tick();
    ovfl_sync_in = 1'b1;
    tick();
    ovfl_sync_in = 1'b0;
    check_eq("ovfl_count5", 32'(ovfl_count), 5);
    ce = 1'b0; ovfl_in = 1'b1;
    repeat (4) tick();
    check_eq("ovfl_hold_ce_low", 32'(ovfl_count), 5);
    ce = 1'b1; ovfl_sync_in = 1'b1;
    tick();
    ovfl_sync_in = 1'b0;
    check_eq("ovfl_ce_low_ignored", 32'(ovfl_count), 0);
    for (int s = 0; s < 3; s++) begin
      repeat (CH - 1) tick();
      ovfl_sync_in = 1'b1;
      tick();
      ovfl_sync_in = 1'b0;
      check_eq("ovfl_full_spectrum", 32'(ovfl_count), 2048);
    end
    repeat (5000) tick();
    ovfl_sync_in = 1'b1;
    tick();
    ovfl_sync_in = 1'b0;
    check_eq("ovfl_saturate", 32'(ovfl_count), 4095);
    ovfl_in = 1'b0;

    // Reset while pending abandons the swap.
    swap_req = 1'b1;
    tick();
    check_eq("rst_pend_wr_ready", 32'(wr_ready), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst2_wr_ready", 32'(wr_ready), 1);
    check_eq("rst2_active_bank", 32'(active_bank), 0);
    check_eq("rst2_gain", 32'(gain_out), 1);
    check_eq("rst2_swap_done", 32'(swap_done), 0);
    check_eq("rst2_ovfl_count", 32'(ovfl_count), 0);
    for (int i = 0; i < CH + 50; i++) begin
      run_cycle(1'b0, 1, "rst2_bypass");
      check_eq("rst2_no_swap_done", 32'(swap_done), 0);
    end
    // First sync after reset arrives off channel 0: no error.
    run_cycle(1'b1, 1, "first_sync");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
